// File: rtl/pio_lcd_status_in_pkg.sv
// Shared constants for the LCD status input PIO: register word addresses,
// edge-type encodings and the prime-counter terminal value.
package pio_lcd_status_in_pkg;

  typedef logic [1:0] addr_t;

  localparam addr_t ADDR_DATA = 2'd0;
  localparam addr_t ADDR_RSVD = 2'd1;
  localparam addr_t ADDR_MASK = 2'd2;
  localparam addr_t ADDR_EDGE = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  // Prime counter saturates here; edges are only trusted once it is reached.
  localparam logic [1:0] PRIME_DONE = 2'd3;

endpackage

// File: rtl/pio_sync_edge.sv
// Two-flop synchronizer per input bit, a previous-sample flop, and
// edge selection (rise, fall or any) on the synchronized value.
module pio_sync_edge
  import pio_lcd_status_in_pkg::*;
#(
  parameter int unsigned Width    = 8,
  parameter int unsigned EdgeType = EDGE_RISE
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] s2_o,
  output logic [Width-1:0] sel_o
);

  logic [Width-1:0] s1_q, s2_q, prev_q;
  logic [Width-1:0] rise, fall;

  // Synchronizer chain plus one-cycle history for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= data_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  // Pick which transitions count as events.
  always_comb begin
    rise = s2_q & ~prev_q;
    fall = ~s2_q & prev_q;
    if (EdgeType == EDGE_FALL) begin
      sel_o = fall;
    end else if (EdgeType == EDGE_ANY) begin
      sel_o = rise | fall;
    end else begin
      sel_o = rise;
    end
  end

  assign s2_o = s2_q;

endmodule

// File: rtl/pio_lcd_status_in.sv
// Avalon-MM input PIO for LCD status/read-back lines: synchronized data
// register, per-bit edge capture with write-1-to-clear, and a maskable
// level interrupt.
module pio_lcd_status_in
  import pio_lcd_status_in_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned EDGE_TYPE = EDGE_RISE,
  parameter logic [31:0] IRQ_RESET = 32'h0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] s2, sel;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] clr;
  logic [1:0]       prime_q, prime_d;
  logic             primed;
  logic             wr_en;
  logic             unused_wdata;

  pio_sync_edge #(
    .Width    (WIDTH),
    .EdgeType (EDGE_TYPE)
  ) u_sync_edge (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .data_i (in_port),
    .s2_o   (s2),
    .sel_o  (sel)
  );

  // Only the low WIDTH bits of writedata carry meaning.
  assign unused_wdata = ^writedata;

  assign wr_en  = chipselect & ~write_n;
  assign primed = (prime_q == PRIME_DONE);

  // Next-state for prime counter, mask and edge capture.
  always_comb begin
    prime_d = primed ? prime_q : prime_q + 2'd1;
    mask_d  = mask_q;
    clr     = '0;
    if (wr_en && address == ADDR_MASK) begin
      mask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && address == ADDR_EDGE) begin
      clr = writedata[WIDTH-1:0];
    end
    // New event wins over a simultaneous clear so nothing is lost.
    cap_d = (primed ? sel : '0) | (cap_q & ~clr);
  end

  // Register state; everything clears asynchronously and priming restarts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prime_q <= '0;
      mask_q  <= IRQ_RESET[WIDTH-1:0];
      cap_q   <= '0;
    end else begin
      prime_q <= prime_d;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
    end
  end

  // Zero-latency read mux, zero-extended above WIDTH.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[WIDTH-1:0] = s2;
      ADDR_RSVD: readdata            = '0;
      ADDR_MASK: readdata[WIDTH-1:0] = mask_q;
      ADDR_EDGE: readdata[WIDTH-1:0] = cap_q;
      default:   readdata            = '0;
    endcase
  end

  assign irq = |(cap_q & mask_q);

endmodule

// File: tb/tb_pio_lcd_status_in.sv
// Directed bench: one rising-edge instance and one any-edge instance
// driven from shared bus and input-port stimulus.
module tb_pio_lcd_status_in;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] rd0, rd2;
  logic        irq0, irq2;

  int vectors;
  int miscompares;

  pio_lcd_status_in #(.WIDTH(8), .EDGE_TYPE(0), .IRQ_RESET(32'h0)) dut0 (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (rd0),
    .irq        (irq0)
  );

  pio_lcd_status_in #(.WIDTH(8), .EDGE_TYPE(2), .IRQ_RESET(32'h0)) dut2 (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (rd2),
    .irq        (irq2)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; land 1 time unit after the rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d0, output logic [31:0] d2);
    address = a;
    #1;
    d0 = rd0;
    d2 = rd2;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
  endtask

  logic [31:0] a0, a2;

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    address     = 2'd0;
    chipselect  = 1'b0;
    write_n     = 1'b1;
    writedata   = 32'h0;
    in_port     = 8'hFF;

    // Reset state with pins high.
    tick(2);
    rd(2'd0, a0, a2);
    chk("reset_data", a0, 32'h0);
    chk("reset_irq", {31'b0, irq0}, 32'h0);

    reset_n = 1'b1;
    tick(1);
    rd(2'd0, a0, a2);
    chk("data_after_1clk", a0, 32'h0);
    tick(1);
    rd(2'd0, a0, a2);
    chk("data_after_2clk", a0, 32'hFF);
    tick(3);
    rd(2'd3, a0, a2);
    chk("no_spurious_cap0", a0, 32'h0);
    chk("no_spurious_cap2", a2, 32'h0);
    chk("irq_after_prime", {31'b0, irq0 | irq2}, 32'h0);

    // Drop all pins; only the any-edge instance records it. Then clear.
    in_port = 8'h00;
    tick(4);
    rd(2'd3, a0, a2);
    chk("fall_all_rise_inst", a0, 32'h00);
    chk("fall_all_any_inst", a2, 32'hFF);
    wr(2'd3, 32'hFF);
    rd(2'd3, a0, a2);
    chk("w1c_all_any_inst", a2, 32'h00);

    // Rising edge on bit 7 with mask 0x80.
    wr(2'd2, 32'h80);
    rd(2'd2, a0, a2);
    chk("mask_readback", a0, 32'h80);
    in_port = 8'h80;
    tick(2);
    rd(2'd3, a0, a2);
    chk("rise_not_yet", a0, 32'h00);
    chk("rise_irq_not_yet", {31'b0, irq0}, 32'h0);
    tick(1);
    rd(2'd3, a0, a2);
    chk("rise_cap0", a0, 32'h80);
    chk("rise_cap2", a2, 32'h80);
    chk("rise_irq0", {31'b0, irq0}, 32'h1);
    chk("rise_irq2", {31'b0, irq2}, 32'h1);
    wr(2'd3, 32'h80);
    chk("w1c_irq0", {31'b0, irq0}, 32'h0);
    chk("w1c_irq2", {31'b0, irq2}, 32'h0);

    // Falling edge on bit 7.
    in_port = 8'h00;
    tick(3);
    rd(2'd3, a0, a2);
    chk("fall_cap_rise_inst", a0, 32'h00);
    chk("fall_irq_rise_inst", {31'b0, irq0}, 32'h0);
    chk("fall_cap_any_inst", a2, 32'h80);
    chk("fall_irq_any_inst", {31'b0, irq2}, 32'h1);
    wr(2'd3, 32'h80);

    // Clear bit 0 on the very edge that captures a new bit-0 event.
    in_port = 8'h01;
    tick(2);
    wr(2'd3, 32'h01);
    rd(2'd3, a0, a2);
    chk("set_wins_cap0", a0, 32'h01);
    chk("set_wins_cap2", a2, 32'h01);
    chk("masked_irq0", {31'b0, irq0}, 32'h0);

    // Unmask a pending bit.
    wr(2'd2, 32'h01);
    chk("unmask_irq0", {31'b0, irq0}, 32'h1);
    chk("unmask_irq2", {31'b0, irq2}, 32'h1);

    // Writes to data and reserved words have no effect.
    wr(2'd0, 32'hFF);
    wr(2'd1, 32'hFF);
    rd(2'd0, a0, a2);
    chk("ro_data", a0, 32'h01);
    rd(2'd1, a0, a2);
    chk("rsvd_reads0", a0, 32'h00);
    rd(2'd2, a0, a2);
    chk("ro_mask_kept", a0, 32'h01);
    rd(2'd3, a0, a2);
    chk("ro_cap_kept", a0, 32'h01);

    // Build capture 0x81, mask 0xFF, then reset mid-cycle.
    wr(2'd2, 32'hFF);
    in_port = 8'h81;
    tick(3);
    rd(2'd3, a0, a2);
    chk("pre_reset_cap", a0, 32'h81);
    chk("pre_reset_irq", {31'b0, irq0}, 32'h1);
    #10;
    reset_n = 1'b0;
    #1;
    chk("async_irq_drop", {31'b0, irq0 | irq2}, 32'h0);
    rd(2'd3, a0, a2);
    chk("async_cap_drop", a0 | a2, 32'h0);
    rd(2'd2, a0, a2);
    chk("mask_reset_val", a0, 32'h0);
    tick(1);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      rd(2'd3, a0, a2);
      chk("post_reset_no_cap", a0 | a2, 32'h0);
    end
    rd(2'd0, a0, a2);
    chk("post_reset_data", a0, 32'h81);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
